// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//   Miss-handling controller for one cache (I or D). On a miss it stalls the
//   pipeline, reads the aligned block from multi-cycle main memory, streams
//   each returned word into the data array, then pulses the tag-array write.
//
// Ports
//   clk                system clock, rising-edge
//   rst_n              synchronous active-low reset (wins over everything)
//   miss_detected      cache lookup missed this cycle
//   miss_address       byte address of the missing access
//   memory_data_valid  memory_data carries the next in-order read response
//   memory_data        read data from main memory
//   fsm_busy           stall request to pipeline/cache
//   mem_read_en        issue a read of memory_address this cycle
//   memory_address     byte address of the current word read (bit0 = 0)
//   write_data_array   write fill_data at word_index this cycle
//   word_index         word offset within the block for the data write
//   fill_data          data to write (pass-through of memory_data)
//   write_tag_array    one-cycle pulse writing tag/valid for the block
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  // One extra bit so the counters can hold WORDS_PER_BLOCK itself.
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);

  // Block size must be a power of two and memory must take at least a cycle.
  if (((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) || (MEM_LATENCY == 0)) begin : g_param_check
    $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  base, base_nxt;
  logic [CNT_W-1:0]   req_cnt, req_nxt;
  logic [CNT_W-1:0]   rsp_cnt, rsp_nxt;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      state   <= state_nxt;
      base    <= base_nxt;
      req_cnt <= req_nxt;
      rsp_cnt <= rsp_nxt;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_nxt        = state;
    base_nxt         = base;
    req_nxt          = req_cnt;
    rsp_nxt          = rsp_cnt;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = rsp_cnt[IDX_W-1:0];
    write_tag_array  = 1'b0;

    case (state)
      IDLE: begin
        // Stall the missing cycle itself so the pipeline never advances past it.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_nxt  = miss_address & ~BLK_MASK;
          req_nxt   = '0;
          rsp_nxt   = '0;
          state_nxt = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Request issue runs ahead of responses; it stops once the block is requested.
        if (req_cnt < CNT_FULL) begin
          mem_read_en    = 1'b1;
          memory_address = base + ADDR_W'({req_cnt, 1'b0});
          req_nxt        = CNT_W'(req_cnt + 1'b1);
        end
        // Responses arrive in order; anything past the last word is dropped.
        if (memory_data_valid && (rsp_cnt < CNT_FULL)) begin
          write_data_array = 1'b1;
          rsp_nxt          = CNT_W'(rsp_cnt + 1'b1);
          if (rsp_cnt == CNT_LAST) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_nxt       = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset dominates: no stall or array/memory strobes while rst_n is low.
    if (!rst_n) begin
      fsm_busy         = 1'b0;
      mem_read_en      = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      word_index       = '0;
      write_tag_array  = 1'b0;
    end
  end

  assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_fsm
//   Directed bench for cache_fill_fsm with a fixed-latency memory model.
//   Each miss pushes its expected reads, data writes, tag write and stall
//   window (by cycle number) into queues; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_cache_fill_fsm;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] fill_data;
  logic        write_tag_array;

  cache_fill_fsm #(
    .WORDS_PER_BLOCK(W),
    .MEM_LATENCY    (LAT),
    .ADDR_W         (16),
    .DATA_W         (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .mem_read_en      (mem_read_en),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .word_index       (word_index),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model: fixed latency, one read per cycle, shares rst_n.
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  logic           spur = 1'b0;
  logic [15:0]    spur_data = 16'h0000;

  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mem_read_en};
      pa[0] <= memory_address;
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
  end

  assign memory_data_valid = pv[LAT-1] | spur;
  assign memory_data       = pv[LAT-1] ? data_of(pa[LAT-1]) : spur_data;

  // Scoreboard.
  typedef struct { int cyc; logic [15:0] addr; }                 rd_t;
  typedef struct { int cyc; logic [2:0] idx; logic [15:0] data; } wr_t;
  typedef struct { int s; int e; }                               bz_t;

  rd_t rq[$];
  wr_t wq[$];
  int  tq[$];
  bz_t bq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Expectations for a full fill whose miss is presented in cycle c.
  task automatic push_fill(input int c, input logic [15:0] a);
    logic [15:0] base;
    rd_t r;
    wr_t w;
    bz_t b;
    base = a & ~16'h000F;
    for (int k = 0; k < int'(W); k++) begin
      r.cyc  = c + 1 + k;
      r.addr = base + 16'(2 * k);
      rq.push_back(r);
      w.cyc  = c + 1 + int'(LAT) + k;
      w.idx  = 3'(k);
      w.data = data_of(base + 16'(2 * k));
      wq.push_back(w);
    end
    tq.push_back(c + 1 + int'(W) + int'(LAT));
    b.s = c;
    b.e = c + 1 + int'(W) + int'(LAT);
    bq.push_back(b);
  endtask

  // Drop every expectation from cycle c onward (reset asserted in cycle c).
  task automatic truncate(input int c);
    while (rq.size() > 0 && rq[rq.size()-1].cyc >= c) void'(rq.pop_back());
    while (wq.size() > 0 && wq[wq.size()-1].cyc >= c) void'(wq.pop_back());
    while (tq.size() > 0 && tq[tq.size()-1] >= c) void'(tq.pop_back());
    while (bq.size() > 0 && bq[bq.size()-1].s >= c) void'(bq.pop_back());
    if (bq.size() > 0 && bq[bq.size()-1].e >= c) bq[bq.size()-1].e = c - 1;
  endtask

  // Monitor: every cycle, compare all strobes against the scoreboard.
  always @(negedge clk) begin
    if (checking) begin
      bit er, ew, et, eb;
      er = (rq.size() > 0) && (rq[0].cyc == cyc);
      ew = (wq.size() > 0) && (wq[0].cyc == cyc);
      et = (tq.size() > 0) && (tq[0] == cyc);
      eb = 1'b0;
      foreach (bq[i]) if (bq[i].s <= cyc && cyc <= bq[i].e) eb = 1'b1;

      chk("mem_read_en", 32'(mem_read_en), 32'(er));
      if (er) begin
        chk("memory_address", 32'(memory_address), 32'(rq[0].addr));
        void'(rq.pop_front());
      end
      chk("write_data_array", 32'(write_data_array), 32'(ew));
      if (ew) begin
        chk("word_index", 32'(word_index), 32'(wq[0].idx));
        chk("fill_data", 32'(fill_data), 32'(wq[0].data));
        void'(wq.pop_front());
      end
      chk("write_tag_array", 32'(write_tag_array), 32'(et));
      if (et) void'(tq.pop_front());
      chk("fsm_busy", 32'(fsm_busy), 32'(eb));
      while (bq.size() > 0 && bq[0].e <= cyc) void'(bq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int c;
    bit drained;

    // 1: reset held two cycles with a miss pending; nothing may fire.
    rst_n         = 1'b0;
    miss_detected = 1'b1;
    miss_address  = 16'h4321;
    ticks(2);
    rst_n         = 1'b1;
    miss_detected = 1'b0;
    ticks(3);

    // 2: single miss, full timing check.
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'h1237;
    push_fill(c, 16'h1237);
    tick();
    miss_detected = 1'b0;
    ticks(16);

    // 3: miss held high through the fill with a wandering address.
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'h1237;
    push_fill(c, 16'h1237);
    for (int k = 1; k <= 13; k++) begin
      tick();
      miss_address = 16'h5550 + 16'(k * 6);
    end
    tick();
    miss_detected = 1'b0;
    ticks(4);

    // 4: top-of-space block, then a back-to-back miss in the first IDLE cycle.
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'hFFFE;
    push_fill(c, 16'hFFFE);
    tick();
    miss_detected = 1'b0;
    ticks(13);
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'h0004;
    push_fill(c, 16'h0004);
    tick();
    miss_detected = 1'b0;
    ticks(16);

    // 5: reset in cycle 7 of a fill, then a clean fill afterwards.
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'h2468;
    push_fill(c, 16'h2468);
    tick();
    miss_detected = 1'b0;
    ticks(6);
    truncate(cyc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(3);
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'h0BAD;
    push_fill(c, 16'h0BAD);
    tick();
    miss_detected = 1'b0;
    ticks(16);

    // 6: spurious responses in IDLE, in DONE and right after the fill.
    spur      = 1'b1;
    spur_data = 16'hDEAD;
    tick();
    spur = 1'b0;
    ticks(2);
    c = cyc;
    miss_detected = 1'b1;
    miss_address  = 16'h7F3A;
    push_fill(c, 16'h7F3A);
    tick();
    miss_detected = 1'b0;
    ticks(12);
    spur      = 1'b1;
    spur_data = 16'hBEEF;
    ticks(2);
    spur = 1'b0;
    ticks(2);

    // Drain: every expected event must have come due within the budget.
    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rq.size() == 0 && wq.size() == 0 && tq.size() == 0 && bq.size() == 0) begin
        drained = 1'b1;
        break;
      end
      tick();
    end
    chk("scoreboard_drain", 32'(drained), 32'd1);

    @(posedge clk);
    checking = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
